riscv_core_fetch_aligner: RTL
=============================

Name: riscv_core_fetch_aligner

Overview:
- Sits between the instruction-fetch interface and the ID stage main decoder.
- Accepts 32-bit, 4-byte-aligned fetch words and splits or joins 16-bit parcels into whole instructions.
- Handles RVC instructions, 32-bit instructions straddling a word boundary, and redirect targets with pc[1]=1.
- Delivers one registered instruction per handshake, with PC, compressed flag and fetch-fault flag; the fault flag feeds the decoder's IF-illegal input.

Parameters:
- XLEN, 64, width of PC values.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_aligner_flush  in  1  redirect; discards all buffered state
- i_aligner_flush_pc  in  XLEN  redirect target; bit0 ignored
- i_aligner_fetch_valid  in  1  fetch word valid
- o_aligner_fetch_ready  out  1  fetch word accepted when valid&ready
- i_aligner_fetch_data  in  32  fetched word, little-endian
- i_aligner_fetch_fault  in  1  access fault for this word
- o_aligner_instr_valid  out  1  instruction slot valid
- i_aligner_instr_ready  in  1  ID stage accepts the slot
- o_aligner_instr  out  32  instruction; RVC parcel zero-extended in [31:16]
- o_aligner_pc  out  XLEN  PC of the instruction
- o_aligner_compressed  out  1  instruction is 16-bit
- o_aligner_if_illegal  out  1  fetch fault attached to the instruction

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - State = ALIGNED, pc = 0, hbuf = 0.
  - o_aligner_instr_valid = 0, o_aligner_instr = 0, o_aligner_pc = 0, o_aligner_compressed = 0, o_aligner_if_illegal = 0.
- Output slot:
  - Single registered entry.
  - Loadable when !o_valid | i_ready ("slot_free").
  - o_* outputs hold stable while valid & !ready.
- Latency: a word accepted in cycle N produces its instruction at the outputs in cycle N+1.
- Parcel rule: a parcel is compressed iff parcel[1:0] != 2'b11.
- States: ALIGNED, HALF (hbuf holds the upper parcel and its PC), SKIP_LO, FAULT.
- ALIGNED, on an accepted word w:
  - w[1:0]==11: emit w (32-bit); pc += 4; stay in ALIGNED.
  - Otherwise: emit {16'h0, w[15:0]} with compressed=1; hbuf = w[31:16], hbuf_pc = pc+2; go to HALF.
- HALF, hbuf compressed:
  - Emit hbuf from the buffer with no fetch consumed; fetch_ready = 0.
  - pc = hbuf_pc + 2; go to ALIGNED.
- HALF, hbuf 32-bit start, on an accepted word w:
  - Emit {w[15:0], hbuf} with pc = hbuf_pc.
  - hbuf = w[31:16], hbuf_pc += 4; stay in HALF.
- SKIP_LO, on an accepted word w:
  - Nothing is emitted.
  - hbuf = w[31:16], hbuf_pc = pc; go to HALF.
  - fetch_ready = 1 regardless of slot_free.
- Fetch fault:
  - Any emission that consumes a faulting word sets if_illegal = 1 and carries the raw data.
  - The PC is that of the instruction start, which is hbuf_pc for a straddling instruction.
  - After the emission, go to FAULT.
- FAULT:
  - fetch_ready = 1, words are discarded, no emission.
  - Exits only on flush.
- fetch_ready:
  - ALIGNED, or HALF with a 32-bit hbuf: equals slot_free.
  - SKIP_LO and FAULT: 1.
  - Forced to 0 while i_aligner_flush = 1.
- Flush (highest priority, also over an in-flight handshake):
  - o_valid = 0, hbuf cleared, pc = flush_pc.
  - state = flush_pc[1] ? SKIP_LO : ALIGNED.
  - A word presented during flush is not accepted.
- i_rst has the same effect as a flush to PC 0 and overrides flush.
- PC arithmetic is modulo 2^XLEN; wrap-around is not flagged.

Optional Feature:
- Macro: RISCV_CORE_ALIGNER_RVC_EN.
- Defined: full behaviour above.
- Undefined:
  - HALF and SKIP_LO are removed and o_aligner_compressed is tied to 0.
  - Every accepted word is emitted as a 32-bit instruction with pc += 4.
  - flush_pc[1] is ignored (cleared); misaligned-target traps are raised elsewhere.

Decomposition:
- riscv_core_pkg holds:
  - The aligner_state_e enum (ALIGNED, HALF, SKIP_LO, FAULT).
  - The XLEN default.
  - The constants PARCEL_W = 16 and RVC_OPCODE_FULL = 2'b11.
- Sub-module riscv_core_aligner_out_reg holds the output slot: valid/ready register of {instr, pc, compressed, if_illegal} with a flush clear.

Test Plan:
- Reset, flush to 0x1000, words 0x00000013 then 0x00A00093 with ready=1 -> emissions at 0x1000 and 0x1004, compressed=0, one per cycle.
- Word 0x45014501 at PC 0x2000 -> slot 0x00004501 at PC 0x2000, then 0x00004501 at PC 0x2002; fetch_ready=0 during the second emission.
- Words 0x00134501 then 0x45010000 -> C 0x4501 at 0x3000, then 32-bit 0x00000013 at 0x3002; hbuf = 0x4501 (compressed), emitted at 0x3006.
- Flush to 0x4002, word 0x0013ABCD, next word 0xXXXX0000 -> low half 0xABCD dropped; 32-bit 0x00000013 at PC 0x4002.
- Word with fault=1 at 0x5000 -> if_illegal=1, PC 0x5000; subsequent words consumed with no emission until flush.
- Hold instr_ready=0 for 3 cycles with valid=1 -> all outputs stable and fetch_ready=0; flush in cycle 2 clears valid on the next edge.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared types and constants for the fetch aligner
// Parcel width, RVC opcode marker, aligner state encoding and XLEN default.
package riscv_core_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int PARCEL_W = 16;
  localparam logic [1:0] RVC_OPCODE_FULL = 2'b11;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HALF    = 2'd1,
    SKIP_LO = 2'd2,
    FAULT   = 2'd3
  } aligner_state_e;

  function automatic logic is_compressed(input logic [1:0] op);
    return op != RVC_OPCODE_FULL;
  endfunction

endpackage

// File: rtl/riscv_core_aligner_out_reg.sv
// rtl/riscv_core_aligner_out_reg.sv - single-entry registered instruction slot
// Holds {instr, pc, compressed, if_illegal} with valid/ready handshake and flush clear.
module riscv_core_aligner_out_reg
  import riscv_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_compressed,
  input  logic            i_if_illegal,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_compressed,
  output logic            o_if_illegal
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_instr      <= '0;
      o_pc         <= '0;
      o_compressed <= 1'b0;
      o_if_illegal <= 1'b0;
    end else begin
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (i_load) begin
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      // payload only moves on a load so it stays stable while stalled
      if (i_load && !i_flush) begin
        o_instr      <= i_instr;
        o_pc         <= i_pc;
        o_compressed <= i_compressed;
        o_if_illegal <= i_if_illegal;
      end
    end
  end

endmodule

// File: rtl/riscv_core_fetch_aligner.sv
// rtl/riscv_core_fetch_aligner.sv - splits/joins 16-bit parcels into whole instructions
// RVC support (HALF/SKIP_LO states) is built only when RISCV_CORE_ALIGNER_RVC_EN is defined.
module riscv_core_fetch_aligner
  import riscv_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_aligner_flush,
  input  logic [XLEN-1:0] i_aligner_flush_pc,
  input  logic            i_aligner_fetch_valid,
  output logic            o_aligner_fetch_ready,
  input  logic [31:0]     i_aligner_fetch_data,
  input  logic            i_aligner_fetch_fault,
  output logic            o_aligner_instr_valid,
  input  logic            i_aligner_instr_ready,
  output logic [31:0]     o_aligner_instr,
  output logic [XLEN-1:0] o_aligner_pc,
  output logic            o_aligner_compressed,
  output logic            o_aligner_if_illegal
);

  aligner_state_e  state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            slot_free;
  logic            accept;
  logic            emit;
  logic [31:0]     e_instr;
  logic [XLEN-1:0] e_pc;
  logic            e_comp;
  logic            e_ill;
  logic            unused_flush_lo;

`ifdef RISCV_CORE_ALIGNER_RVC_EN
  logic [PARCEL_W-1:0] hbuf, hbuf_nxt;
  logic [XLEN-1:0]     hbuf_pc, hbuf_pc_nxt;
  logic                hbuf_fault, hbuf_fault_nxt;
  logic                hbuf_c;
  logic                word_c;

  assign hbuf_c          = is_compressed(hbuf[1:0]);
  assign word_c          = is_compressed(i_aligner_fetch_data[1:0]);
  assign unused_flush_lo = i_aligner_flush_pc[0];
`else
  assign unused_flush_lo = ^i_aligner_flush_pc[1:0];
`endif

  assign slot_free = !o_aligner_instr_valid || i_aligner_instr_ready;
  assign accept    = i_aligner_fetch_valid && o_aligner_fetch_ready;

  always_comb begin
    o_aligner_fetch_ready = 1'b0;
    if (!i_aligner_flush) begin
      case (state)
        ALIGNED: o_aligner_fetch_ready = slot_free;
`ifdef RISCV_CORE_ALIGNER_RVC_EN
        HALF:    o_aligner_fetch_ready = hbuf_c ? 1'b0 : slot_free;
        SKIP_LO: o_aligner_fetch_ready = 1'b1;
`endif
        FAULT:   o_aligner_fetch_ready = 1'b1;
        default: o_aligner_fetch_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    emit      = 1'b0;
    e_instr   = '0;
    e_pc      = pc;
    e_comp    = 1'b0;
    e_ill     = 1'b0;
`ifdef RISCV_CORE_ALIGNER_RVC_EN
    hbuf_nxt       = hbuf;
    hbuf_pc_nxt    = hbuf_pc;
    hbuf_fault_nxt = hbuf_fault;
`endif
    if (i_aligner_flush) begin
`ifdef RISCV_CORE_ALIGNER_RVC_EN
      pc_nxt         = {i_aligner_flush_pc[XLEN-1:1], 1'b0};
      state_nxt      = i_aligner_flush_pc[1] ? SKIP_LO : ALIGNED;
      hbuf_nxt       = '0;
      hbuf_pc_nxt    = '0;
      hbuf_fault_nxt = 1'b0;
`else
      pc_nxt    = {i_aligner_flush_pc[XLEN-1:2], 2'b00};
      state_nxt = ALIGNED;
`endif
    end else begin
      case (state)
        ALIGNED: begin
          if (accept) begin
            emit  = 1'b1;
            e_pc  = pc;
            e_ill = i_aligner_fetch_fault;
`ifdef RISCV_CORE_ALIGNER_RVC_EN
            if (word_c) begin
              e_instr        = {16'h0, i_aligner_fetch_data[15:0]};
              e_comp         = 1'b1;
              hbuf_nxt       = i_aligner_fetch_data[31:16];
              hbuf_pc_nxt    = pc + XLEN'(2);
              hbuf_fault_nxt = 1'b0;
              state_nxt      = HALF;
            end else begin
              e_instr = i_aligner_fetch_data;
              pc_nxt  = pc + XLEN'(4);
            end
`else
            e_instr = i_aligner_fetch_data;
            pc_nxt  = pc + XLEN'(4);
`endif
            if (i_aligner_fetch_fault) state_nxt = FAULT;
          end
        end
`ifdef RISCV_CORE_ALIGNER_RVC_EN
        HALF: begin
          if (hbuf_c) begin
            if (slot_free) begin
              emit      = 1'b1;
              e_instr   = {16'h0, hbuf};
              e_pc      = hbuf_pc;
              e_comp    = 1'b1;
              e_ill     = hbuf_fault;
              pc_nxt    = hbuf_pc + XLEN'(2);
              state_nxt = hbuf_fault ? FAULT : ALIGNED;
            end
          end else if (accept) begin
            // straddling instruction reports the PC of its first parcel
            emit        = 1'b1;
            e_instr     = {i_aligner_fetch_data[15:0], hbuf};
            e_pc        = hbuf_pc;
            e_ill       = i_aligner_fetch_fault || hbuf_fault;
            hbuf_nxt    = i_aligner_fetch_data[31:16];
            hbuf_pc_nxt = hbuf_pc + XLEN'(4);
            if (i_aligner_fetch_fault || hbuf_fault) state_nxt = FAULT;
          end
        end
        SKIP_LO: begin
          if (accept) begin
            hbuf_nxt       = i_aligner_fetch_data[31:16];
            hbuf_pc_nxt    = pc;
            hbuf_fault_nxt = i_aligner_fetch_fault;
            state_nxt      = HALF;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ALIGNED;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

`ifdef RISCV_CORE_ALIGNER_RVC_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hbuf       <= '0;
      hbuf_pc    <= '0;
      hbuf_fault <= 1'b0;
    end else begin
      hbuf       <= hbuf_nxt;
      hbuf_pc    <= hbuf_pc_nxt;
      hbuf_fault <= hbuf_fault_nxt;
    end
  end
`endif

  riscv_core_aligner_out_reg #(.XLEN(XLEN)) u_out_reg (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_aligner_flush),
    .i_load       (emit),
    .i_ready      (i_aligner_instr_ready),
    .i_instr      (e_instr),
    .i_pc         (e_pc),
    .i_compressed (e_comp),
    .i_if_illegal (e_ill),
    .o_valid      (o_aligner_instr_valid),
    .o_instr      (o_aligner_instr),
    .o_pc         (o_aligner_pc),
    .o_compressed (o_aligner_compressed),
    .o_if_illegal (o_aligner_if_illegal)
  );

endmodule
